// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the core data-memory to SRAM bridge.
// Holds the bridge FSM state encoding, the data/byte-enable widths and the
// latency counter width (wide enough for the largest supported read latency).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Counter must hold MEM_LATENCY-1 for MEM_LATENCY up to 8.
  localparam int CNT_W  = $clog2(8) + 1;

endpackage

// File: rtl/dmem_bridge.sv
// dmem_bridge: one-at-a-time bridge from the core data-memory port to a word-addressed SRAM.
// Latency: mem_cs one cycle after the request is sampled; store valid 2 cycles after; load valid 1+MEM_LATENCY cycles after.
// Backpressure: core holds request until valid; requests outside IDLE are ignored, never queued.
// Optional: DMEM_RANGE_CHECK_EN adds an err output and suppresses SRAM access for addresses beyond the SRAM depth.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [BE_W-1:0]   mask,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] store_data,
  output logic              valid,
  output logic [WORD_W-1:0] load_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic              lat_oor;
  logic              oor_req;
  logic [WORD_W-1:0] load_hold;
  logic [WORD_W-1:0] resp_word;

  // Byte offset is meaningless to a word SRAM: the core has already lane-aligned the data.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor_req = |address[31:ADDR_W+2];
`else
  // Upper address bits are dropped so accesses wrap modulo the SRAM depth.
  logic unused_addr_msb;
  assign unused_addr_msb = ^address[31:ADDR_W+2];
  assign oor_req = 1'b0;
`endif

  // Out-of-range loads return zero instead of whatever the SRAM bus carries.
  assign resp_word = lat_oor ? '0 : mem_rdata;

  // SRAM read data is only valid during the response cycle, so it is forwarded
  // there and kept in load_hold afterwards until the next load response.
  always_comb begin
    load_data = load_hold;
    if (state == RESP && !lat_we) load_data = resp_word;
  end

  // Transaction FSM: latch request, pulse the SRAM access, wait out read latency, pulse valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      load_hold <= '0;
      valid     <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low; the SRAM bus is zero whenever mem_cs is low.
      valid     <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (request) begin
            lat_we  <= we_re;
            lat_oor <= oor_req;
            if (!oor_req) begin
              mem_cs    <= 1'b1;
              mem_we    <= we_re;
              mem_be    <= mask;
              mem_addr  <= address[ADDR_W+1:2];
              mem_wdata <= store_data;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we || lat_oor || MEM_LATENCY == 1) begin
            valid <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
            err   <= lat_oor;
`endif
            state <= RESP;
          end else begin
            cnt   <= CNT_W'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            valid <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (!lat_we) load_hold <= resp_word;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/sram_model.sv
// sram_model: bench-only synchronous word SRAM with byte-enabled writes.
// Read data appears LATENCY cycles after the mem_cs cycle and only for that one
// cycle (zero otherwise), so a response sampled on the wrong cycle reads as zero.
module sram_model #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
)(
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem  [0:(1<<ADDR_W)-1];
  logic [31:0] pipe [0:LATENCY-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    for (int i = 0; i < LATENCY; i++) pipe[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (cs && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    pipe[0] <= (cs && !we) ? mem[addr] : 32'h0;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[LATENCY-1];

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: bench for dmem_bridge with one MEM_LATENCY=1 instance (u1)
// and one MEM_LATENCY=4 instance (u4), each backed by an sram_model.
// Build with DMEM_RANGE_CHECK_EN defined to exercise the err path.
module tb_dmem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r1_req = 0, r1_we = 0;
  logic [3:0]  r1_mask = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0;
  logic        v1, cs1, we1, err1;
  logic [31:0] ld1, wd1, rd1;
  logic [3:0]  be1;
  logic [9:0]  ad1;

  logic        r4_req = 0, r4_we = 0;
  logic [3:0]  r4_mask = 0;
  logic [31:0] r4_addr = 0, r4_wdata = 0;
  logic        v4, cs4, we4, err4;
  logic [31:0] ld4, wd4, rd4;
  logic [3:0]  be4;
  logic [9:0]  ad4;

  dmem_bridge #(.ADDR_W(10), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .request(r1_req), .we_re(r1_we), .mask(r1_mask),
    .address(r1_addr), .store_data(r1_wdata), .valid(v1), .load_data(ld1),
    .mem_cs(cs1), .mem_we(we1), .mem_be(be1), .mem_addr(ad1), .mem_wdata(wd1),
    .mem_rdata(rd1)
`ifdef DMEM_RANGE_CHECK_EN
    , .err(err1)
`endif
  );

  dmem_bridge #(.ADDR_W(10), .MEM_LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .request(r4_req), .we_re(r4_we), .mask(r4_mask),
    .address(r4_addr), .store_data(r4_wdata), .valid(v4), .load_data(ld4),
    .mem_cs(cs4), .mem_we(we4), .mem_be(be4), .mem_addr(ad4), .mem_wdata(wd4),
    .mem_rdata(rd4)
`ifdef DMEM_RANGE_CHECK_EN
    , .err(err4)
`endif
  );

`ifndef DMEM_RANGE_CHECK_EN
  assign err1 = 1'b0;
  assign err4 = 1'b0;
`endif

  sram_model #(.ADDR_W(10), .LATENCY(1)) m1 (
    .clk(clk), .cs(cs1), .we(we1), .be(be1), .addr(ad1), .wdata(wd1), .rdata(rd1));
  sram_model #(.ADDR_W(10), .LATENCY(4)) m4 (
    .clk(clk), .cs(cs4), .we(we4), .be(be4), .addr(ad4), .wdata(wd4), .rdata(rd4));

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard of expected load words, pushed at stimulus time.
  logic [31:0] sb_q[$];

  // Observations from the last drive() call; cycle numbers count from the
  // edge that sampled the request (1 = first cycle after it, -1 = never).
  int          r_cs_n, r_cs1, r_cs2, r_v1, r_nv;
  logic        r_cs_we, r_verr, r_bus_bad;
  logic [3:0]  r_cs_be;
  logic [9:0]  r_cs_addr;
  logic [31:0] r_cs_wdata, r_vdata;

  // Core model: raise request, hold it until the drop_on-th valid, observe 6 more cycles.
  task automatic drive(input bit sel, input logic we, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d, input int drop_on);
    int k, extra;
    logic s_cs, s_v, s_we, s_err;
    logic [3:0] s_be;
    logic [9:0] s_ad;
    logic [31:0] s_wd, s_ld;
    r_cs_n = 0; r_cs1 = -1; r_cs2 = -1; r_v1 = -1; r_nv = 0;
    r_cs_we = 0; r_verr = 0; r_bus_bad = 0; r_cs_be = 0; r_cs_addr = 0;
    r_cs_wdata = 0; r_vdata = 0;
    @(negedge clk);
    if (sel) begin
      r4_req = 1; r4_we = we; r4_mask = m; r4_addr = a; r4_wdata = d;
    end else begin
      r1_req = 1; r1_we = we; r1_mask = m; r1_addr = a; r1_wdata = d;
    end
    @(posedge clk);
    k = 0; extra = 0;
    while (k < 60 && extra < 6) begin
      @(negedge clk);
      k++;
      s_cs = sel ? cs4 : cs1;  s_v  = sel ? v4  : v1;   s_we  = sel ? we4  : we1;
      s_be = sel ? be4 : be1;  s_ad = sel ? ad4 : ad1;  s_wd  = sel ? wd4  : wd1;
      s_ld = sel ? ld4 : ld1;  s_err = sel ? err4 : err1;
      if (s_cs) begin
        r_cs_n++;
        if (r_cs1 < 0) begin
          r_cs1 = k; r_cs_we = s_we; r_cs_be = s_be; r_cs_addr = s_ad; r_cs_wdata = s_wd;
        end else if (r_cs2 < 0) r_cs2 = k;
      end else if (s_we || s_be != 0 || s_ad != 0 || s_wd != 0) r_bus_bad = 1;
      if (s_v) begin
        r_nv++;
        if (r_v1 < 0) begin r_v1 = k; r_vdata = s_ld; r_verr = s_err; end
      end
      if (r_nv >= drop_on) begin
        if (sel) r4_req = 0; else r1_req = 0;
        extra++;
      end
    end
    if (sel) r4_req = 0; else r1_req = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({v1, cs1, we1, be1, ad1, wd1} !== '0) $display("FAIL reset_u1_bus got %h want 0", {v1, cs1, we1, be1, ad1, wd1}); else n_pass++;
    n_chk++; if (ld1 !== 32'h0) $display("FAIL reset_u1_load_data got %h want 0", ld1); else n_pass++;
    n_chk++; if ({v4, cs4, we4, be4, ad4, wd4, ld4} !== '0) $display("FAIL reset_u4_outputs got %h want 0", {v4, cs4, we4, be4, ad4, wd4, ld4}); else n_pass++;
    n_chk++; if ({err1, err4} !== 2'b00) $display("FAIL reset_err got %b want 00", {err1, err4}); else n_pass++;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_store_load();
    logic [31:0] exp;
    drive(0, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    n_chk++; if (r_cs1 !== 1) $display("FAIL st_cs_cycle got %0d want 1", r_cs1); else n_pass++;
    n_chk++; if (r_cs_addr !== 10'd4) $display("FAIL st_mem_addr got %0d want 4", r_cs_addr); else n_pass++;
    n_chk++; if ({r_cs_we, r_cs_be} !== 5'b1_1111) $display("FAIL st_we_be got %b want 11111", {r_cs_we, r_cs_be}); else n_pass++;
    n_chk++; if (r_cs_wdata !== 32'hDEAD_BEEF) $display("FAIL st_wdata got %h want deadbeef", r_cs_wdata); else n_pass++;
    n_chk++; if (r_v1 !== 2 || r_nv !== 1) $display("FAIL st_valid got cycle %0d count %0d want cycle 2 count 1", r_v1, r_nv); else n_pass++;
    n_chk++; if (r_verr !== 1'b0) $display("FAIL st_err got %b want 0", r_verr); else n_pass++;
    n_chk++; if (r_bus_bad !== 1'b0) $display("FAIL st_idle_bus got %b want 0", r_bus_bad); else n_pass++;
    sb_q.push_back(32'hDEAD_BEEF);
    drive(0, 0, 4'hF, 32'h0000_0010, 32'h0, 1);
    exp = sb_q.pop_front();
    n_chk++; if (r_cs_we !== 1'b0 || r_cs_addr !== 10'd4) $display("FAIL ld_issue got we %b addr %0d want we 0 addr 4", r_cs_we, r_cs_addr); else n_pass++;
    n_chk++; if (r_v1 !== 2 || r_nv !== 1) $display("FAIL ld_valid got cycle %0d count %0d want cycle 2 count 1", r_v1, r_nv); else n_pass++;
    n_chk++; if (r_vdata !== exp) $display("FAIL ld_data got %h want %h", r_vdata, exp); else n_pass++;
    n_chk++; if (ld1 !== exp) $display("FAIL ld_data_held got %h want %h", ld1, exp); else n_pass++;
  endtask

  task automatic test_byte_store();
    logic [31:0] exp;
    drive(0, 1, 4'h8, 32'h0000_0013, 32'hAB00_0000, 1);
    n_chk++; if (r_cs_be !== 4'h8 || r_cs_addr !== 10'd4) $display("FAIL byte_be_addr got be %h addr %0d want be 8 addr 4", r_cs_be, r_cs_addr); else n_pass++;
    drive(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1);
    n_chk++; if (r_cs_n !== 1 || r_cs_be !== 4'h0 || r_cs_we !== 1'b1) $display("FAIL mask0_issue got n %0d be %h we %b want n 1 be 0 we 1", r_cs_n, r_cs_be, r_cs_we); else n_pass++;
    n_chk++; if (r_v1 !== 2) $display("FAIL mask0_valid got cycle %0d want 2", r_v1); else n_pass++;
    sb_q.push_back(32'hABAD_BEEF);
    drive(0, 0, 4'hF, 32'h0000_0010, 32'h0, 1);
    exp = sb_q.pop_front();
    n_chk++; if (r_vdata !== exp) $display("FAIL byte_load got %h want %h", r_vdata, exp); else n_pass++;
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    drive(1, 1, 4'hF, 32'h0000_0040, 32'h1234_5678, 1);
    n_chk++; if (r_v1 !== 2 || r_cs_addr !== 10'd16) $display("FAIL lat4_store got cycle %0d addr %0d want cycle 2 addr 16", r_v1, r_cs_addr); else n_pass++;
    sb_q.push_back(32'h1234_5678);
    drive(1, 0, 4'hF, 32'h0000_0040, 32'h0, 1);
    exp = sb_q.pop_front();
    n_chk++; if (r_cs_n !== 1 || r_cs1 !== 1) $display("FAIL lat4_single_cs got n %0d cycle %0d want n 1 cycle 1", r_cs_n, r_cs1); else n_pass++;
    n_chk++; if (r_v1 !== 5 || r_nv !== 1) $display("FAIL lat4_valid got cycle %0d count %0d want cycle 5 count 1", r_v1, r_nv); else n_pass++;
    n_chk++; if (r_vdata !== exp) $display("FAIL lat4_data got %h want %h", r_vdata, exp); else n_pass++;
  endtask

  task automatic test_wrap();
`ifdef DMEM_RANGE_CHECK_EN
    drive(0, 1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, 1);
    n_chk++; if (r_cs_n !== 0) $display("FAIL oor_store_cs got %0d want 0", r_cs_n); else n_pass++;
    n_chk++; if (r_v1 !== 2 || r_verr !== 1'b1) $display("FAIL oor_store_resp got cycle %0d err %b want cycle 2 err 1", r_v1, r_verr); else n_pass++;
    drive(0, 0, 4'hF, 32'h0000_1004, 32'h0, 1);
    n_chk++; if (r_vdata !== 32'h0 || r_verr !== 1'b1 || r_v1 !== 2) $display("FAIL oor_load got data %h err %b cycle %0d want 0 1 2", r_vdata, r_verr, r_v1); else n_pass++;
    n_chk++; if (ld1 !== 32'h0) $display("FAIL oor_load_held got %h want 0", ld1); else n_pass++;
`else
    logic [31:0] exp;
    drive(0, 1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, 1);
    n_chk++; if (r_cs_addr !== 10'd1 || r_cs_n !== 1) $display("FAIL wrap_addr got %0d n %0d want 1 n 1", r_cs_addr, r_cs_n); else n_pass++;
    sb_q.push_back(32'hCAFE_F00D);
    drive(0, 0, 4'hF, 32'h0000_0004, 32'h0, 1);
    exp = sb_q.pop_front();
    n_chk++; if (r_vdata !== exp) $display("FAIL wrap_load got %h want %h", r_vdata, exp); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 4'hF, 32'h0000_0020, 32'h55AA_55AA, 2);
    n_chk++; if (r_cs_n !== 2 || r_cs2 - r_cs1 !== 3) $display("FAIL b2b_store got n %0d gap %0d want n 2 gap 3", r_cs_n, r_cs2 - r_cs1); else n_pass++;
    n_chk++; if (r_nv !== 2) $display("FAIL b2b_store_valids got %0d want 2", r_nv); else n_pass++;
    sb_q.push_back(32'h55AA_55AA);
    drive(0, 0, 4'hF, 32'h0000_0020, 32'h0, 2);
    n_chk++; if (r_cs_n !== 2 || r_cs2 - r_cs1 !== 3) $display("FAIL b2b_load got n %0d gap %0d want n 2 gap 3", r_cs_n, r_cs2 - r_cs1); else n_pass++;
    n_chk++; if (r_vdata !== sb_q.pop_front()) $display("FAIL b2b_load_data got %h want 55aa55aa", r_vdata); else n_pass++;
  endtask

  task automatic test_async_reset();
    int nv = 0;
    int ncs = 0;
    logic [31:0] exp;
    @(negedge clk);
    r4_req = 1; r4_we = 0; r4_mask = 4'hF; r4_addr = 32'h0000_0040;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (cs4 !== 1'b1) $display("FAIL rst_issue_cs got %b want 1", cs4); else n_pass++;
    @(posedge clk);
    #2 rst = 1;
    #1;
    n_chk++; if ({v4, cs4, we4, be4, ad4, wd4, ld4} !== '0) $display("FAIL rst_midflight got %h want 0", {v4, cs4, we4, be4, ad4, wd4, ld4}); else n_pass++;
    @(negedge clk);
    rst = 0; r4_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (v4) nv++;
      if (cs4) ncs++;
    end
    n_chk++; if (nv !== 0 || ncs !== 0) $display("FAIL rst_no_valid got valid %0d cs %0d want 0 0", nv, ncs); else n_pass++;
    sb_q.push_back(32'h1234_5678);
    drive(1, 0, 4'hF, 32'h0000_0040, 32'h0, 1);
    exp = sb_q.pop_front();
    n_chk++; if (r_v1 !== 5 || r_vdata !== exp) $display("FAIL rst_recover got cycle %0d data %h want 5 %h", r_v1, r_vdata, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
